// File: rtl/mat_switch.sv
// mat_switch: inter-core switch shared by all MatCores of the tensor array.
//
// Each (source, destination) core pair owns a single-entry mailbox that holds
// one SWITCH_WIDTH vector of shortreal. A mailbox has exactly one writer (its
// source port) and one reader (its destination port), so no arbitration is
// needed. The switch is the responder end of both handshakes.
//
// Payload elements are carried as raw IEEE-754 single-precision bit patterns
// (32 bits each, i.e. the bit image of a shortreal). The switch never does
// arithmetic on them, so data moves bit-exact.
//
// Configuration macro:
//   MAT_SWITCH_BYPASS_EN - when defined, a read and a write that hit an empty
//                          mailbox at the same edge forward send_data straight
//                          to recv_data; the mailbox stays empty.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   send_ready     per source: send request, held until send_ok
//   send_core_idx  per source: destination core index
//   send_data      per source: payload vector
//   send_ok        per source: one-cycle acknowledge pulse
//   recv_request   per destination: receive request, held until recv_ready
//   recv_core_idx  per destination: requested source core index
//   recv_ready     per destination: one-cycle data-valid pulse
//   recv_data      per destination: last delivered vector
//   mbox_full      bit s*SWITCH_CORE_SIZE+d set while mailbox (s,d) holds data
module mat_switch #(
  parameter int unsigned SWITCH_WIDTH          = 16,
  parameter int unsigned SWITCH_CORE_SIZE      = 4,
  parameter int unsigned SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                                                    clock,
  input  logic                                                    reset,
  input  logic [SWITCH_CORE_SIZE-1:0]                             send_ready,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]  send_core_idx,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]     send_data,
  output logic [SWITCH_CORE_SIZE-1:0]                             send_ok,
  input  logic [SWITCH_CORE_SIZE-1:0]                             recv_request,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]  recv_core_idx,
  output logic [SWITCH_CORE_SIZE-1:0]                             recv_ready,
  output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]     recv_data,
  output logic [SWITCH_CORE_SIZE*SWITCH_CORE_SIZE-1:0]            mbox_full
);

  localparam int unsigned N  = SWITCH_CORE_SIZE;
  localparam int unsigned NB = SWITCH_CORE_SIZE * SWITCH_CORE_SIZE;

  typedef logic [SWITCH_WIDTH-1:0][31:0] vec_t;

  typedef enum logic {SendIdle, SendAck}  send_st_e;
  typedef enum logic {RecvIdle, RecvData} recv_st_e;

  send_st_e send_st_q [N];
  send_st_e send_st_d [N];
  recv_st_e recv_st_q [N];
  recv_st_e recv_st_d [N];

  logic [NB-1:0] full_q, full_d;
  logic [NB-1:0] wr_ok;   // mailbox accepts its source's write this edge
  logic [NB-1:0] rd_ok;   // mailbox serves its destination's read this edge
  logic [NB-1:0] byp;     // read served straight from send_data (empty mailbox)
  vec_t          mbox_q [NB];

  logic [N-1:0]  send_acc;
  logic [N-1:0]  recv_acc;
  logic [N-1:0][SWITCH_WIDTH-1:0][31:0] recv_data_q, recv_data_d;

  // Per-mailbox decode. Index m = s*N + d matches the mbox_full layout.
  for (genvar s = 0; s < N; s++) begin : g_src
    for (genvar d = 0; d < N; d++) begin : g_dst
      localparam int unsigned M = s * N + d;
      logic w_hit;
      logic r_hit;

      assign w_hit = (send_st_q[s] == SendIdle) && send_ready[s] &&
                     (send_core_idx[s] == SWITCH_CORE_ADDR_SIZE'(d));
      assign r_hit = (recv_st_q[d] == RecvIdle) && recv_request[d] &&
                     (recv_core_idx[d] == SWITCH_CORE_ADDR_SIZE'(s));

`ifdef MAT_SWITCH_BYPASS_EN
      assign byp[M] = w_hit && r_hit && !full_q[M];
`else
      assign byp[M] = 1'b0;
`endif

      // A full mailbox still takes a write when the same edge drains it.
      assign wr_ok[M]  = w_hit && (!full_q[M] || r_hit);
      assign rd_ok[M]  = r_hit && (full_q[M] || byp[M]);
      assign full_d[M] = byp[M]   ? 1'b0 :
                         wr_ok[M] ? 1'b1 :
                         rd_ok[M] ? 1'b0 : full_q[M];
    end
  end

  // Per-port acceptance and delivered data.
  always_comb begin
    send_acc    = '0;
    recv_acc    = '0;
    recv_data_d = recv_data_q;
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (wr_ok[s*N+d]) begin
          send_acc[s] = 1'b1;
        end
        if (rd_ok[s*N+d]) begin
          recv_acc[d]    = 1'b1;
          // Old contents on a full mailbox; forwarded payload on a bypass.
          recv_data_d[d] = full_q[s*N+d] ? mbox_q[s*N+d] : send_data[s];
        end
      end
    end
  end

  // Port FSMs: next state and Moore pulse outputs.
  always_comb begin
    for (int p = 0; p < N; p++) begin
      send_st_d[p] = send_st_q[p];
      recv_st_d[p] = recv_st_q[p];
      case (send_st_q[p])
        SendIdle: if (send_acc[p]) send_st_d[p] = SendAck;
        SendAck:  send_st_d[p] = SendIdle;
        default:  send_st_d[p] = SendIdle;
      endcase
      case (recv_st_q[p])
        RecvIdle: if (recv_acc[p]) recv_st_d[p] = RecvData;
        RecvData: recv_st_d[p] = RecvIdle;
        default:  recv_st_d[p] = RecvIdle;
      endcase
      send_ok[p]    = (send_st_q[p] == SendAck);
      recv_ready[p] = (recv_st_q[p] == RecvData);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < N; p++) begin
        send_st_q[p] <= SendIdle;
        recv_st_q[p] <= RecvIdle;
      end
      full_q      <= '0;
      recv_data_q <= '0;
    end else begin
      for (int p = 0; p < N; p++) begin
        send_st_q[p] <= send_st_d[p];
        recv_st_q[p] <= recv_st_d[p];
      end
      full_q      <= full_d;
      recv_data_q <= recv_data_d;
    end
  end

  // Mailbox payload needs no reset: the full flags qualify every read.
  always_ff @(posedge clock) begin
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (wr_ok[s*N+d] && !byp[s*N+d]) begin
          mbox_q[s*N+d] <= send_data[s];
        end
      end
    end
  end

  assign recv_data = recv_data_q;
  assign mbox_full = full_q;

endmodule

// File: tb/tb_mat_switch.sv
// Scoreboard testbench for mat_switch (default parameters: 4 cores, 16 lanes).
// Stimulus pushes expected pulses (with an allowed cycle window) and expected
// flag snapshots into queues; a monitor on the falling edge pops and compares.
module tb_mat_switch;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned A  = 2;
  localparam int unsigned NB = 16;

`ifdef MAT_SWITCH_BYPASS_EN
  localparam int RecvWaitLat = 6;
  localparam int EmptySimLat = 1;
  localparam logic [NB-1:0] EmptySimFlags = 16'h0000;
`else
  localparam int RecvWaitLat = 7;
  localparam int EmptySimLat = 2;
  localparam logic [NB-1:0] EmptySimFlags = 16'h0002;
`endif

  typedef logic [W-1:0][31:0] vec_t;
  typedef struct {
    int   port;
    int   lo;
    int   hi;
    vec_t data;
  } exp_t;
  typedef struct {
    int            stamp;
    logic [NB-1:0] flags;
    bit            zero;
  } flg_t;

  logic                     clock;
  logic                     reset;
  logic [N-1:0]             send_ready;
  logic [N-1:0][A-1:0]      send_core_idx;
  logic [N-1:0][W-1:0][31:0] send_data;
  logic [N-1:0]             send_ok;
  logic [N-1:0]             recv_request;
  logic [N-1:0][A-1:0]      recv_core_idx;
  logic [N-1:0]             recv_ready;
  logic [N-1:0][W-1:0][31:0] recv_data;
  logic [NB-1:0]            mbox_full;

  mat_switch #(
    .SWITCH_WIDTH     (W),
    .SWITCH_CORE_SIZE (N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .send_data     (send_data),
    .send_ok       (send_ok),
    .recv_request  (recv_request),
    .recv_core_idx (recv_core_idx),
    .recv_ready    (recv_ready),
    .recv_data     (recv_data),
    .mbox_full     (mbox_full)
  );

  exp_t send_q[$];
  exp_t recv_q[$];
  flg_t flg_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;
  int   mk;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // IEEE-754 single constants
  localparam logic [31:0] F1 = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2 = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3 = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F4 = 32'h4080_0000;  // 4.0
  localparam logic [31:0] F5 = 32'h40A0_0000;  // 5.0
  localparam logic [31:0] F6 = 32'h40C0_0000;  // 6.0
  localparam logic [31:0] F7 = 32'h40E0_0000;  // 7.0

  function automatic vec_t fill(logic [31:0] b);
    vec_t v;
    for (int i = 0; i < W; i++) v[i] = b;
    return v;
  endfunction

  // Bit pattern of (i + 0.5): (2i+1) * 2^-1 with 2i+1 a small odd integer.
  function automatic logic [31:0] half_bits(int i);
    logic [31:0] n;
    logic [31:0] m;
    int          e;
    n = 32'(2 * i + 1);
    e = 0;
    for (int k = 0; k < 31; k++) if (n[k]) e = k;
    m = (n << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(126 + e), m[22:0]};
  endfunction

  function automatic vec_t half_vec();
    vec_t v;
    for (int i = 0; i < W; i++) v[i] = half_bits(i);
    return v;
  endfunction

  // Advance to the next falling edge; drop requests whose pulse is visible.
  task automatic tick();
    @(negedge clock);
    for (int p = 0; p < N; p++) begin
      if (send_ok[p])    send_ready[p]   = 1'b0;
      if (recv_ready[p]) recv_request[p] = 1'b0;
    end
  endtask

  task automatic issue_send(int s, int d, vec_t v, int lo, int hi);
    send_ready[s]    = 1'b1;
    send_core_idx[s] = A'(d);
    send_data[s]     = v;
    send_q.push_back('{port: s, lo: cyc + lo, hi: cyc + hi, data: v});
  endtask

  task automatic issue_recv(int d, int s, vec_t v, int lo, int hi, bit push);
    recv_request[d]  = 1'b1;
    recv_core_idx[d] = A'(s);
    if (push) recv_q.push_back('{port: d, lo: cyc + lo, hi: cyc + hi, data: v});
  endtask

  task automatic expect_flags(logic [NB-1:0] f, bit zero);
    flg_q.push_back('{stamp: cyc + 1, flags: f, zero: zero});
  endtask

  // Monitor: the only place comparisons are made and counted.
  always @(negedge clock) begin
    for (int s = 0; s < N; s++) begin
      if (send_ok[s]) begin
        mk = -1;
        for (int i = 0; i < send_q.size(); i++) if (mk < 0 && send_q[i].port == s) mk = i;
        total++;
        if (mk < 0) begin
          bad++;
          $display("FAIL send_ok_unexpected port=%0d cyc=%0d got=1 want=0", s, cyc);
        end else begin
          if (cyc < send_q[mk].lo || cyc > send_q[mk].hi) begin
            bad++;
            $display("FAIL send_ok_timing port=%0d got_cyc=%0d want_cyc=[%0d,%0d]",
                     s, cyc, send_q[mk].lo, send_q[mk].hi);
          end
          send_q.delete(mk);
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      if (recv_ready[d]) begin
        mk = -1;
        for (int i = 0; i < recv_q.size(); i++) if (mk < 0 && recv_q[i].port == d) mk = i;
        total++;
        if (mk < 0) begin
          bad++;
          $display("FAIL recv_ready_unexpected port=%0d cyc=%0d got=1 want=0", d, cyc);
        end else begin
          if (cyc < recv_q[mk].lo || cyc > recv_q[mk].hi) begin
            bad++;
            $display("FAIL recv_timing port=%0d got_cyc=%0d want_cyc=[%0d,%0d]",
                     d, cyc, recv_q[mk].lo, recv_q[mk].hi);
          end
          total++;
          if (recv_data[d] !== recv_q[mk].data) begin
            bad++;
            $display("FAIL recv_data port=%0d got=%h want=%h", d, recv_data[d], recv_q[mk].data);
          end
          recv_q.delete(mk);
        end
      end
    end
    for (int i = send_q.size() - 1; i >= 0; i--) begin
      if (send_q[i].hi < cyc) begin
        total++;
        bad++;
        $display("FAIL send_ok_timeout port=%0d got=none want_by_cyc=%0d", send_q[i].port,
                 send_q[i].hi);
        send_q.delete(i);
      end
    end
    for (int i = recv_q.size() - 1; i >= 0; i--) begin
      if (recv_q[i].hi < cyc) begin
        total++;
        bad++;
        $display("FAIL recv_timeout port=%0d got=none want_by_cyc=%0d", recv_q[i].port,
                 recv_q[i].hi);
        recv_q.delete(i);
      end
    end
    while (flg_q.size() > 0 && flg_q[0].stamp <= cyc) begin
      total++;
      if (mbox_full !== flg_q[0].flags) begin
        bad++;
        $display("FAIL mbox_full cyc=%0d got=%h want=%h", cyc, mbox_full, flg_q[0].flags);
      end
      if (flg_q[0].zero) begin
        total++;
        if (send_ok !== '0 || recv_ready !== '0 || recv_data !== '0) begin
          bad++;
          $display("FAIL reset_outputs cyc=%0d got send_ok=%b recv_ready=%b data_nonzero=%0d want 0",
                   cyc, send_ok, recv_ready, (recv_data !== '0));
        end
      end
      void'(flg_q.pop_front());
    end
    if (done) begin
      total++;
      if (send_q.size() != 0 || recv_q.size() != 0 || flg_q.size() != 0) begin
        bad++;
        $display("FAIL pending_at_end got send=%0d recv=%0d flags=%0d want 0 0 0",
                 send_q.size(), recv_q.size(), flg_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no_end want=end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with traffic driven on every port.
    reset         = 1'b0;
    send_ready    = '1;
    send_core_idx = {2'd0, 2'd3, 2'd2, 2'd1};
    for (int p = 0; p < N; p++) send_data[p] = fill(F5);
    recv_request  = '1;
    recv_core_idx = {2'd2, 2'd1, 2'd0, 2'd3};
    repeat (3) begin
      expect_flags('0, 1'b1);
      tick();
    end
    send_ready   = '0;
    recv_request = '0;
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Basic transfer 1 -> 2, mailbox bit 6.
    issue_send(1, 2, half_vec(), 1, 1);
    expect_flags(16'h0040, 1'b0);
    tick();
    tick();
    issue_recv(2, 1, half_vec(), 1, 1, 1'b1);
    expect_flags(16'h0000, 1'b0);
    tick();
    tick();

    // Backpressure 0 -> 3: second send waits for the first to drain.
    issue_send(0, 3, fill(F1), 1, 1);
    expect_flags(16'h0008, 1'b0);
    tick();
    tick();
    issue_send(0, 3, fill(F2), 11, 11);
    repeat (10) tick();
    issue_recv(3, 0, fill(F1), 1, 1, 1'b1);
    expect_flags(16'h0008, 1'b0);
    tick();
    tick();
    issue_recv(3, 0, fill(F2), 1, 1, 1'b1);
    expect_flags(16'h0000, 1'b0);
    tick();
    tick();

    // Recv waits on empty mailbox (0,2), then 7.0 arrives.
    issue_recv(2, 0, fill(F7), RecvWaitLat, RecvWaitLat, 1'b1);
    repeat (5) tick();
    issue_send(0, 2, fill(F7), 1, 1);
    repeat (3) tick();
    expect_flags(16'h0000, 1'b0);
    tick();

    // Simultaneous read/write on full mailbox (0,1).
    issue_send(0, 1, fill(F3), 1, 1);
    tick();
    tick();
    issue_send(0, 1, fill(F4), 1, 1);
    issue_recv(1, 0, fill(F3), 1, 1, 1'b1);
    expect_flags(16'h0002, 1'b0);
    tick();
    tick();
    issue_recv(1, 0, fill(F4), 1, 1, 1'b1);
    expect_flags(16'h0000, 1'b0);
    tick();
    tick();

    // Simultaneous read/write on empty mailbox (0,1).
    issue_send(0, 1, fill(F4), 1, 1);
    issue_recv(1, 0, fill(F4), EmptySimLat, EmptySimLat, 1'b1);
    expect_flags(EmptySimFlags, 1'b0);
    repeat (3) tick();
    expect_flags(16'h0000, 1'b0);
    tick();

    // Self-send 2 -> 2.
    issue_send(2, 2, fill(F6), 1, 1);
    tick();
    tick();
    issue_recv(2, 2, fill(F6), 1, 1, 1'b1);
    tick();
    tick();

    // Fill (0,1) and (2,2), then reset mid-operation.
    issue_send(0, 1, fill(F5), 1, 1);
    issue_send(2, 2, fill(F6), 1, 1);
    expect_flags(16'h0402, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    expect_flags(16'h0000, 1'b1);
    tick();
    reset = 1'b1;
    issue_recv(1, 0, fill(F5), 0, 0, 1'b0);  // must never be served
    repeat (8) tick();
    expect_flags(16'h0000, 1'b0);
    tick();
    recv_request[1] = 1'b0;
    repeat (3) tick();
    done = 1'b1;
  end

endmodule

// File: doc/mat_switch.md
Name: mat_switch

Overview:
- Inter-core switch serving the switch_send_* / switch_recv_* ports of every MatCore in the tensor array.
- It is the responder end of both handshakes: it accepts send requests and acknowledges them with send_ok, and it answers recv requests with recv_ready plus data.
- Internally it holds one single-entry mailbox per (source, destination) core pair, each storing one SWITCH_WIDTH vector of shortreal.
- Each mailbox has exactly one writer (its source port) and one reader (its destination port), so no arbitration is needed.

Parameters:
- SWITCH_WIDTH, 16, shortreal elements per transferred vector.
- SWITCH_CORE_SIZE, 4, number of attached cores; must be a power of two, minimum 2.
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE), core index width (auto-gen).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- send_ready  in  [SWITCH_CORE_SIZE]  per source core: send request, held until acknowledged.
- send_core_idx  in  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  per source core: destination core index.
- send_data  in  shortreal [SWITCH_CORE_SIZE][SWITCH_WIDTH]  per source core: payload vector.
- send_ok  out  [SWITCH_CORE_SIZE]  per source core: one-cycle acknowledge pulse.
- recv_request  in  [SWITCH_CORE_SIZE]  per destination core: receive request, held until served.
- recv_core_idx  in  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  per destination core: requested source core index.
- recv_ready  out  [SWITCH_CORE_SIZE]  per destination core: one-cycle data-valid pulse.
- recv_data  out  shortreal [SWITCH_CORE_SIZE][SWITCH_WIDTH]  per destination core: delivered vector.
- mbox_full  out  [SWITCH_CORE_SIZE*SWITCH_CORE_SIZE]  occupancy flags; bit s*SWITCH_CORE_SIZE+d is set when mailbox (s,d) holds data.

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - all mailboxes are empty (mbox_full=0);
  - send_ok=0 and recv_ready=0;
  - recv_data is all 0.0;
  - every port FSM is in IDLE.
- A reset asserted mid-transfer discards mailbox contents and cancels any pending pulse.
- Send FSM, one per source port s, states IDLE and ACK:
  - IDLE: if send_ready[s]=1 and mailbox (s, send_core_idx[s]) is empty at the edge, write send_data[s] into it, set its full flag, and go to ACK.
  - IDLE: if the mailbox is full, stay in IDLE. The request waits with no ok and no data change.
  - ACK: send_ok[s]=1 for exactly this cycle. send_ready[s] is ignored. Next state is IDLE.
  - The source must drop send_ready in the cycle after it sees send_ok; otherwise a new send is accepted.
  - Send latency is 1 cycle: request seen at edge N gives send_ok high in cycle N+1.
- Recv FSM, one per destination port d, states IDLE and DATA:
  - IDLE: if recv_request[d]=1 and mailbox (recv_core_idx[d], d) is full at the edge, register its contents into recv_data[d], clear the full flag, and go to DATA.
  - IDLE: if the mailbox is empty, the request waits.
  - DATA: recv_ready[d]=1 for exactly this cycle. recv_request[d] is ignored. Next state is IDLE.
  - recv_data[d] holds its last value until the next delivery.
- Simultaneous write and read of the same mailbox at one edge:
  - Mailbox full: the read takes the old data and the write stores the new data. The flag stays set, both pulses fire, and no data is lost.
  - Mailbox empty: only the write happens and the read waits. This is the no-bypass default; see the optional feature.
- Self-send (s==d) is legal and uses mailbox (s,s).
- Ordering: each pair is strictly FIFO with depth 1. Different pairs are fully independent and may all transfer in the same cycle.
- Data is moved bit-exact; the switch performs no arithmetic.

Optional Feature:
- Macro: MAT_SWITCH_BYPASS_EN.
- Defined: a read and a write hitting an empty mailbox at the same edge bypass it.
  - send_data is forwarded directly to recv_data.
  - Both pulses fire and the mailbox stays empty.
  - Best-case latency from send to receive drops from 2 edges to 1.
- Undefined: the no-bypass behaviour above applies.

Test Plan:
- Reset: hold reset=0 for 3 cycles with traffic driven -> send_ok=0, recv_ready=0, mbox_full=0, recv_data all 0.0.
- Basic transfer:
  - core1 sends to core2 with data[i]=i+0.5 -> send_ok[1] pulses one cycle later, and bit 6 of mbox_full sets.
  - core2 then requests from src 1 -> recv_ready[2] pulses with data[i]=i+0.5, and bit 6 clears.
- Backpressure:
  - core0 sends 1.0 then 2.0 to core3 with no recv -> the second send gets no send_ok for 10 cycles.
  - core3 then receives -> gets 1.0; the second send_ok follows, then the next receive gets 2.0.
- Recv wait: core2 requests from src 0 with the mailbox empty for 5 cycles -> no recv_ready; core0 then sends 7.0 -> recv_ready[2] pulses with 7.0.
- Simultaneous:
  - Full mailbox (0,1) holding 3.0, with a concurrent send of 4.0 and a recv -> the recv gets 3.0, send_ok fires, and the mailbox then holds 4.0.
  - Repeat with the mailbox empty, with and without MAT_SWITCH_BYPASS_EN -> recv gets 4.0 on the same edge (bypass) or one FSM round later (no bypass).
- Reset mid-operation: fill mailboxes (0,1) and (2,2), then assert reset for 1 cycle -> all flags clear, and a subsequent recv from src 0 waits indefinitely.
